// File: rtl/regfile_write_arbiter_if.sv
// Bundles the two producer request channels and the register file write
// port of regfile_write_arbiter.
//   master : producer side (drives wb_*/aux_* requests, observes readies and
//            the registered write port)
//   slave  : arbiter side (accepts requests, drives readies and the write port)
//   wb_valid/wb_reg/wb_data     writeback request, wb_ready accept
//   aux_valid/aux_reg/aux_data  auxiliary request, aux_ready accept
//   write/writeReg/writeData    registered register file write port
//   init_done                   register clear sequence finished
interface regfile_write_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;
  logic              aux_valid;
  logic [ADDR_W-1:0] aux_reg;
  logic [DATA_W-1:0] aux_data;
  logic              aux_ready;
  logic              write;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic              init_done;

  modport master (
    output wb_valid, wb_reg, wb_data, aux_valid, aux_reg, aux_data,
    input  wb_ready, aux_ready, write, writeReg, writeData, init_done
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data, aux_valid, aux_reg, aux_data,
    output wb_ready, aux_ready, write, writeReg, writeData, init_done
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the single register file write port between the writeback stage
// (wb) and a multi-cycle auxiliary unit (aux). After reset it clears
// registers 1..NUM_REGS-1, then arbitrates with wb priority; aux is forced
// to win after STARVE_LIMIT consecutive losses.
// Ports:
//   clk    system clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    regfile_write_arbiter_if.slave (requests, readies, write port)
module regfile_write_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int NUM_REGS     = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_write_arbiter_if.slave  bus
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam int CLR_W = $clog2(NUM_REGS) + 1;
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);

  // Saturating increment of the starvation counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= CNT_MAX) return CNT_MAX;
    return v + 1'b1;
  endfunction

  logic [0:0]        state;
  logic [CLR_W-1:0]  clr_idx;
  logic [CNT_W-1:0]  starve_cnt;

  logic              write_p1;
  logic [ADDR_W-1:0] write_reg_p1;
  logic [DATA_W-1:0] write_data_p1;
  logic              init_done_p1;

  logic              run_p0;
  logic              starved_p0;
  logic              grant_aux_p0;
  logic              grant_wb_p0;
  logic [ADDR_W-1:0] sel_reg_p0;
  logic [DATA_W-1:0] sel_data_p0;

  // ---- stage p0: combinational arbitration on the incoming requests ----
  always_comb begin
    run_p0       = (state == ST_RUN);
    starved_p0   = (starve_cnt == CNT_MAX);
    grant_aux_p0 = run_p0 && bus.aux_valid && (!bus.wb_valid || starved_p0);
    grant_wb_p0  = run_p0 && bus.wb_valid && !grant_aux_p0;
    sel_reg_p0   = grant_aux_p0 ? bus.aux_reg  : bus.wb_reg;
    sel_data_p0  = grant_aux_p0 ? bus.aux_data : bus.wb_data;
  end

  assign bus.wb_ready  = run_p0 && !grant_aux_p0;
  assign bus.aux_ready = run_p0 && (grant_aux_p0 || !bus.wb_valid);

  // ---- stage p1: registered write port, clear sequencer, starvation ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_CLEAR;
      clr_idx       <= CLR_W'(1);
      starve_cnt    <= '0;
      write_p1      <= 1'b0;
      write_reg_p1  <= '0;
      write_data_p1 <= '0;
      init_done_p1  <= 1'b0;
    end else if (state == ST_CLEAR) begin
      write_p1      <= 1'b1;
      write_reg_p1  <= ADDR_W'(clr_idx);
      write_data_p1 <= '0;
      clr_idx       <= clr_idx + 1'b1;
      if (clr_idx == CLR_LAST) begin
        state        <= ST_RUN;
        init_done_p1 <= 1'b1;
      end
    end else begin
      if (grant_aux_p0 || grant_wb_p0) begin
        // Writes to register 0 are accepted but never reach the regfile.
        write_p1 <= (sel_reg_p0 != '0);
        if (sel_reg_p0 != '0) begin
          write_reg_p1  <= sel_reg_p0;
          write_data_p1 <= sel_data_p0;
        end
      end else begin
        write_p1 <= 1'b0;
      end

      if (!bus.aux_valid || grant_aux_p0) starve_cnt <= '0;
      else                                starve_cnt <= sat_inc(starve_cnt);
    end
  end

  assign bus.write     = write_p1;
  assign bus.writeReg  = write_reg_p1;
  assign bus.writeData = write_data_p1;
  assign bus.init_done = init_done_p1;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 32;
  localparam int NUM_REGS     = 32;
  localparam int STARVE_LIMIT = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // Reference model state: consecutive aux losses and expected write port.
  int                losses;
  logic              exp_write;
  logic [ADDR_W-1:0] exp_reg;
  logic [DATA_W-1:0] exp_data;
  logic              port_known;
  logic              last_aux_acc;

  regfile_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_write_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .NUM_REGS(NUM_REGS), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic model_reset();
    losses       = 0;
    exp_write    = 1'b1;
    exp_reg      = ADDR_W'(NUM_REGS - 1);
    exp_data     = '0;
    port_known   = 1'b1;
    last_aux_acc = 1'b0;
  endtask

  task automatic drive_idle();
    bus.wb_valid  = 1'b0;
    bus.wb_reg    = '0;
    bus.wb_data   = '0;
    bus.aux_valid = 1'b0;
    bus.aux_reg   = '0;
    bus.aux_data  = '0;
  endtask

  // Runs the clear sequence from just after reset release.
  task automatic clear_seq();
    for (int i = 1; i < NUM_REGS; i++) begin
      bus.wb_valid  = 1'b1;
      bus.wb_reg    = 5'd3;
      bus.aux_valid = 1'b0;
      #2;
      check("clr_wb_ready", {63'd0, bus.wb_ready}, 64'd0);
      check("clr_aux_ready", {63'd0, bus.aux_ready}, 64'd0);
      @(posedge clk); #1;
      check("clr_write", {63'd0, bus.write}, 64'd1);
      check("clr_reg", {59'd0, bus.writeReg}, 64'(i));
      check("clr_data", {32'd0, bus.writeData}, 64'd0);
      check("clr_init_done", {63'd0, bus.init_done}, (i == NUM_REGS - 1) ? 64'd1 : 64'd0);
    end
    drive_idle();
    model_reset();
  endtask

  // One RUN cycle: called just after a posedge; drives requests, checks the
  // accepts, then checks the registered write port after the next edge.
  task automatic cycle(input logic wv, input logic [ADDR_W-1:0] wr, input logic [DATA_W-1:0] wd,
                       input logic av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad);
    logic ga, gw;
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
    bus.wb_valid  = wv;
    bus.wb_reg    = wr;
    bus.wb_data   = wd;
    bus.aux_valid = av;
    bus.aux_reg   = ar;
    bus.aux_data  = ad;
    // aux wins if wb is idle or aux has already lost STARVE_LIMIT times in a row
    ga = av && (!wv || losses >= STARVE_LIMIT);
    gw = wv && !ga;
    #2;
    check("wb_accept", {63'd0, bus.wb_valid && bus.wb_ready}, {63'd0, gw});
    check("aux_accept", {63'd0, bus.aux_valid && bus.aux_ready}, {63'd0, ga});
    if (ga || gw) begin
      r = ga ? ar : wr;
      d = ga ? ad : wd;
      if (r == '0) begin
        exp_write  = 1'b0;
        port_known = 1'b0;
      end else begin
        exp_write  = 1'b1;
        exp_reg    = r;
        exp_data   = d;
        port_known = 1'b1;
      end
    end else begin
      exp_write = 1'b0;
    end
    if (!av || ga) losses = 0;
    else if (losses < STARVE_LIMIT) losses++;
    last_aux_acc = ga;
    @(posedge clk); #1;
    check("run_write", {63'd0, bus.write}, {63'd0, exp_write});
    if (port_known) begin
      check("run_reg", {59'd0, bus.writeReg}, {59'd0, exp_reg});
      check("run_data", {32'd0, bus.writeData}, {32'd0, exp_data});
    end
    check("run_init_done", {63'd0, bus.init_done}, 64'd1);
  endtask

  initial begin
    logic              av;
    logic [ADDR_W-1:0] ar;
    logic [DATA_W-1:0] ad;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive_idle();
    model_reset();

    // Reset state
    #1;
    check("rst_write", {63'd0, bus.write}, 64'd0);
    check("rst_reg", {59'd0, bus.writeReg}, 64'd0);
    check("rst_data", {32'd0, bus.writeData}, 64'd0);
    check("rst_init_done", {63'd0, bus.init_done}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Clear sequence
    clear_seq();
    cycle(0, 0, 0, 0, 0, 0);

    // wb only
    cycle(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    check("wb_only_data", {32'd0, bus.writeData}, 64'hDEADBEEF);

    // Both valid every cycle: wb x4 then aux; then wb again
    for (int k = 0; k < 6; k++)
      cycle(1, 5'(10 + k), 32'h100 + 32'(k), 1, 5'd20, 32'hA5A5_0001);
    cycle(0, 0, 0, 0, 0, 0);

    // Register 0 discarded, then aux alone
    cycle(1, 5'd0, 32'h1234, 0, 0, 0);
    check("reg0_write", {63'd0, bus.write}, 64'd0);
    cycle(0, 0, 0, 1, 5'd7, 32'h7777_0007);
    check("aux_alone_reg", {59'd0, bus.writeReg}, 64'd7);

    // Same-register conflict resolved by starvation: 0x22 then 0x11
    for (int k = 0; k < 4; k++)
      cycle(1, 5'(12 + k), 32'h200 + 32'(k), 1, 5'd9, 32'h22);
    cycle(1, 5'd9, 32'h11, 1, 5'd9, 32'h22);
    check("conflict_first", {32'd0, bus.writeData}, 64'h22);
    cycle(1, 5'd9, 32'h11, 0, 0, 0);
    check("conflict_final", {32'd0, bus.writeData}, 64'h11);

    // Randomized traffic; aux holds its request until accepted
    av = 1'b0; ar = '0; ad = '0;
    for (int k = 0; k < 300; k++) begin
      if (!av || last_aux_acc) begin
        av = ($urandom_range(0, 99) < 60);
        ar = 5'($urandom_range(0, NUM_REGS - 1));
        ad = $urandom;
      end
      cycle(($urandom_range(0, 99) < 70), 5'($urandom_range(0, NUM_REGS - 1)), $urandom, av, ar, ad);
    end
    drive_idle();

    // Reset in the middle of the clear sequence
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
    end
    check("midclr_reg", {59'd0, bus.writeReg}, 64'd12);
    rst_n = 1'b0;
    #1;
    check("midclr_write", {63'd0, bus.write}, 64'd0);
    check("midclr_reg_rst", {59'd0, bus.writeReg}, 64'd0);
    check("midclr_init_done", {63'd0, bus.init_done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_seq();
    cycle(1, 5'd3, 32'hCAFE_F00D, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
